// File: rtl/soc_pkg.sv
// Shared definitions for the boot loader: frame constants, FSM state type, SRAM strobe.
package soc_pkg;

    localparam logic [7:0] MAGIC_DEFAULT = 8'hA5;
    localparam logic [3:0] WSTRB_WORD    = 4'b1111;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN0,
        ST_LEN1,
        ST_DATA,
        ST_WRITE,
        ST_CSUM,
        ST_DONE,
        ST_ERROR
    } state_e;

endpackage

// File: rtl/loader_word_asm.sv
// Little-endian word assembler: shifts bytes into a 32-bit word, tracks the byte index
// and accumulates the XOR checksum over every payload byte.
module loader_word_asm (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic [7:0]  csum_o,
    output logic        word_done_o
);

    logic [31:0] word_q;
    logic [7:0]  csum_q;
    logic [1:0]  idx_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_q <= '0;
            csum_q <= '0;
            idx_q  <= '0;
        end else if (clr_i) begin
            word_q <= '0;
            csum_q <= '0;
            idx_q  <= '0;
        end else if (byte_valid_i) begin
            // Shifting in from the top leaves the first byte of the word in [7:0].
            word_q <= {byte_i, word_q[31:8]};
            csum_q <= csum_q ^ byte_i;
            idx_q  <= idx_q + 2'd1;
        end
    end

    assign word_o      = word_q;
    assign csum_o      = csum_q;
    assign word_done_o = byte_valid_i && (idx_q == 2'd3);

endmodule

// File: rtl/uart_loader.sv
// Boot loader: parses a framed image from the UART byte stream, writes it into SRAM,
// then releases the CPU. Owns the SRAM port only until cpu_run goes high.
module uart_loader
    import soc_pkg::*;
#(
    parameter int unsigned ADDRWIDTH = 13,
    parameter logic [7:0]  MAGIC     = MAGIC_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx_valid,
    input  logic [7:0]           rx_data,
    output logic                 mem_select,
    output logic [3:0]           mem_wstrb,
    output logic [ADDRWIDTH-1:0] mem_addr,
    output logic [31:0]          mem_data_o,
    input  logic                 mem_ready,
    output logic                 cpu_run,
    output logic                 busy,
    output logic                 error
);

    localparam int unsigned IDXW      = ADDRWIDTH - 2;
    localparam logic [16:0] MAX_WORDS = 17'(1) << IDXW;

    state_e          state_q;
    logic [15:0]     count_q;
    logic [IDXW-1:0] word_idx_q;
    logic [7:0]      hold_q;
    logic            hold_full_q;
    logic            wr_first_q;
    logic            sel_q;
    logic [3:0]      wstrb_q;
    logic            run_q;
    logic            err_q;
    logic            busy_q;

    logic            in_stream;
    logic            byte_v;
    logic [7:0]      cur_byte;
    logic            asm_clr;
    logic            asm_v;
    logic [15:0]     len_d;
    logic            last_word;
    logic            word_done;
    logic [31:0]     asm_word;
    logic [7:0]      asm_csum;

    // A held byte always takes precedence over a fresh one in the payload states.
    always_comb begin
        in_stream = (state_q == ST_DATA) || (state_q == ST_CSUM);
        byte_v    = (in_stream && hold_full_q) || rx_valid;
        cur_byte  = (in_stream && hold_full_q) ? hold_q : rx_data;
        asm_clr   = (state_q == ST_IDLE) && rx_valid && (rx_data == MAGIC);
        asm_v     = (state_q == ST_DATA) && byte_v;
        len_d     = {rx_data, count_q[7:0]};
        last_word = (17'(word_idx_q) + 17'd1) == {1'b0, count_q};
    end

    loader_word_asm u_asm (
        .clk          (clk),
        .rst          (reset),
        .clr_i        (asm_clr),
        .byte_valid_i (asm_v),
        .byte_i       (cur_byte),
        .word_o       (asm_word),
        .csum_o       (asm_csum),
        .word_done_o  (word_done)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            count_q     <= '0;
            word_idx_q  <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            wr_first_q  <= 1'b0;
            sel_q       <= 1'b0;
            wstrb_q     <= '0;
            run_q       <= 1'b0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (asm_clr) begin
                        state_q    <= ST_LEN0;
                        busy_q     <= 1'b1;
                        word_idx_q <= '0;
                    end
                end
                ST_LEN0: begin
                    if (rx_valid) begin
                        count_q[7:0] <= rx_data;
                        state_q      <= ST_LEN1;
                    end
                end
                ST_LEN1: begin
                    if (rx_valid) begin
                        count_q <= len_d;
                        if ({1'b0, len_d} > MAX_WORDS) begin
                            state_q <= ST_ERROR;
                            err_q   <= 1'b1;
                            busy_q  <= 1'b0;
                        end else if (len_d == '0) begin
                            state_q <= ST_CSUM;
                        end else begin
                            state_q <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (hold_full_q && !rx_valid) begin
                        hold_full_q <= 1'b0;
                    end else if (hold_full_q) begin
                        hold_q <= rx_data;
                    end
                    if (word_done) begin
                        state_q    <= ST_WRITE;
                        sel_q      <= 1'b1;
                        wstrb_q    <= WSTRB_WORD;
                        wr_first_q <= 1'b1;
                    end
                end
                ST_WRITE: begin
                    if (rx_valid && hold_full_q) begin
                        state_q <= ST_ERROR;
                        err_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        sel_q   <= 1'b0;
                        wstrb_q <= '0;
                    end else begin
                        if (rx_valid) begin
                            hold_q      <= rx_data;
                            hold_full_q <= 1'b1;
                        end
                        // Ready seen in the first cycle belongs to the previous access.
                        if (wr_first_q) begin
                            wr_first_q <= 1'b0;
                        end else if (mem_ready) begin
                            sel_q      <= 1'b0;
                            wstrb_q    <= '0;
                            word_idx_q <= word_idx_q + IDXW'(1);
                            state_q    <= last_word ? ST_CSUM : ST_DATA;
                        end
                    end
                end
                ST_CSUM: begin
                    if (byte_v) begin
                        hold_full_q <= 1'b0;
                        busy_q      <= 1'b0;
                        if (cur_byte == asm_csum) begin
                            state_q <= ST_DONE;
                            run_q   <= 1'b1;
                        end else begin
                            state_q <= ST_ERROR;
                            err_q   <= 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign mem_select = sel_q;
    assign mem_wstrb  = wstrb_q;
    assign mem_addr   = {word_idx_q, 2'b00};
    assign mem_data_o = asm_word;
    assign cpu_run    = run_q;
    assign busy       = busy_q;
    assign error      = err_q;

endmodule
